// File: rtl/axi_lite_sram_slave_pkg.sv
// rtl/axi_lite_sram_slave_pkg.sv - shared AXI-Lite constants and FSM state encodings
package axi_lite_sram_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

endpackage

// File: rtl/axi_lite_sram_mem.sv
// rtl/axi_lite_sram_mem.sv - word array with async read port and byte-strobed sync write port
module axi_lite_sram_mem #(
    parameter int MEM_DEPTH  = 4096,
    parameter int DATA_WIDTH = 32,
    localparam int IDX_W     = $clog2(MEM_DEPTH),
    localparam int STRB_W    = DATA_WIDTH / 8
) (
    input  logic                  i_clk,
    input  logic [IDX_W-1:0]      i_rd_idx,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_wr_idx,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [STRB_W-1:0]     i_wr_strb
);

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // Reads see the array as it stands before this edge's write, giving read-before-write.
    assign o_rd_data = r_mem[i_rd_idx];

    // Commit only the strobed byte lanes.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wr_strb[b]) begin
                    r_mem[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axi_lite_sram_slave.sv
// rtl/axi_lite_sram_slave.sv - AXI4-Lite SRAM responder with configurable read/write latency
module axi_lite_sram_slave
    import axi_lite_sram_slave_pkg::*;
#(
    parameter int                    ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = AXI_DATA_WIDTH,
    parameter int                    MEM_DEPTH  = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    RD_LATENCY = 2,
    parameter int                    WR_LATENCY = 2
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready
);

    localparam int                    STRB_WIDTH = DATA_WIDTH / 8;
    localparam int                    IDX_W      = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] SPAN       = ADDR_WIDTH'(4 * MEM_DEPTH);
    localparam logic [3:0]            RD_LAT     = 4'(RD_LATENCY);
    localparam logic [3:0]            WR_LAT     = 4'(WR_LATENCY);

    rd_state_t               r_rstate;
    logic [3:0]              r_rcnt;
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic                    r_arready;
    logic                    r_rvalid;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [1:0]              r_rresp;

    wr_state_t               r_wstate;
    logic [3:0]              r_wcnt;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_WIDTH-1:0]   r_wstrb;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic                    r_awready;
    logic                    r_wready;
    logic                    r_bvalid;
    logic [1:0]              r_bresp;

    logic                    w_ar_hs;
    logic [ADDR_WIDTH-1:0]   w_rd_addr;
    logic [ADDR_WIDTH-1:0]   w_rd_off;
    logic                    w_rd_hit;
    logic [IDX_W-1:0]        w_rd_idx;
    logic                    w_rd_fire;
    logic [DATA_WIDTH-1:0]   w_mem_rdata;

    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_aw_have;
    logic                    w_w_have;
    logic [ADDR_WIDTH-1:0]   w_wr_addr;
    logic [ADDR_WIDTH-1:0]   w_wr_off;
    logic                    w_wr_hit;
    logic [IDX_W-1:0]        w_wr_idx;
    logic [DATA_WIDTH-1:0]   w_wr_data;
    logic [STRB_WIDTH-1:0]   w_wr_strb;
    logic                    w_wr_fire;
    logic                    w_mem_we;

    // With zero latency the access fires on the handshake edge itself, so decode the live address then.
    assign w_ar_hs   = r_arready & s_arvalid;
    assign w_rd_addr = (r_rstate == R_IDLE) ? s_araddr : r_araddr;
    assign w_rd_off  = w_rd_addr - BASE_ADDR;
    assign w_rd_hit  = (w_rd_addr >= BASE_ADDR) && (w_rd_off < SPAN);
    assign w_rd_idx  = w_rd_off[IDX_W+1:2];
    assign w_rd_fire = ((r_rstate == R_IDLE) && w_ar_hs && (RD_LAT == 4'd0)) ||
                       ((r_rstate == R_WAIT) && (r_rcnt == 4'd1));

    assign w_aw_hs   = r_awready & s_awvalid;
    assign w_w_hs    = r_wready & s_wvalid;
    assign w_aw_have = r_aw_done | w_aw_hs;
    assign w_w_have  = r_w_done | w_w_hs;
    assign w_wr_addr = ((r_wstate == W_IDLE) && !r_aw_done) ? s_awaddr : r_awaddr;
    assign w_wr_data = ((r_wstate == W_IDLE) && !r_w_done) ? s_wdata : r_wdata;
    assign w_wr_strb = ((r_wstate == W_IDLE) && !r_w_done) ? s_wstrb : r_wstrb;
    assign w_wr_off  = w_wr_addr - BASE_ADDR;
    assign w_wr_hit  = (w_wr_addr >= BASE_ADDR) && (w_wr_off < SPAN);
    assign w_wr_idx  = w_wr_off[IDX_W+1:2];
    assign w_wr_fire = ((r_wstate == W_IDLE) && w_aw_have && w_w_have && (WR_LAT == 4'd0)) ||
                       ((r_wstate == W_WAIT) && (r_wcnt == 4'd1));
    assign w_mem_we  = w_wr_fire & w_wr_hit;

    axi_lite_sram_mem #(
        .MEM_DEPTH  (MEM_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .i_clk     (aclk),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_mem_rdata),
        .i_we      (w_mem_we),
        .i_wr_idx  (w_wr_idx),
        .i_wr_data (w_wr_data),
        .i_wr_strb (w_wr_strb)
    );

    // Read channel FSM: accept AR, count down latency, present and hold R until taken.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_rstate  <= R_IDLE;
            r_rcnt    <= 4'd0;
            r_araddr  <= '0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (w_ar_hs) begin
                        r_araddr  <= s_araddr;
                        r_arready <= 1'b0;
                        r_rcnt    <= RD_LAT;
                        if (w_rd_fire) begin
                            r_rdata  <= w_rd_hit ? w_mem_rdata : '0;
                            r_rresp  <= w_rd_hit ? RESP_OKAY : RESP_SLVERR;
                            r_rvalid <= 1'b1;
                            r_rstate <= R_RESP;
                        end else begin
                            r_rstate <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (w_rd_fire) begin
                        r_rdata  <= w_rd_hit ? w_mem_rdata : '0;
                        r_rresp  <= w_rd_hit ? RESP_OKAY : RESP_SLVERR;
                        r_rvalid <= 1'b1;
                        r_rstate <= R_RESP;
                    end else begin
                        r_rcnt <= r_rcnt - 4'd1;
                    end
                end
                R_RESP: begin
                    if (s_rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // Write channel FSM: collect AW and W independently, count down latency, commit, then hold B until taken.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_wstate  <= W_IDLE;
            r_wcnt    <= 4'd0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_awaddr  <= s_awaddr;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wdata  <= s_wdata;
                        r_wstrb  <= s_wstrb;
                        r_w_done <= 1'b1;
                    end
                    r_awready <= !w_aw_have;
                    r_wready  <= !w_w_have;
                    if (w_aw_have && w_w_have) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_wcnt    <= WR_LAT;
                        if (w_wr_fire) begin
                            r_bresp  <= w_wr_hit ? RESP_OKAY : RESP_SLVERR;
                            r_bvalid <= 1'b1;
                            r_wstate <= W_RESP;
                        end else begin
                            r_wstate <= W_WAIT;
                        end
                    end
                end
                W_WAIT: begin
                    if (w_wr_fire) begin
                        r_bresp  <= w_wr_hit ? RESP_OKAY : RESP_SLVERR;
                        r_bvalid <= 1'b1;
                        r_wstate <= W_RESP;
                    end else begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                W_RESP: begin
                    if (s_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    assign s_arready = r_arready;
    assign s_rvalid  = r_rvalid;
    assign s_rdata   = r_rdata;
    assign s_rresp   = r_rresp;
    assign s_awready = r_awready;
    assign s_wready  = r_wready;
    assign s_bvalid  = r_bvalid;
    assign s_bresp   = r_bresp;

endmodule

// File: doc/axi_lite_sram_slave.md
Name: axi_lite_sram_slave

Overview:
- AXI4-Lite responder that sits at the far end of the core's AXI arbiter and services IFU instruction fetches and LSU loads/stores.
- Holds a word-addressed SRAM behind the AR/R and AW/W/B channels.
- Read and write latency are configurable, so the core's stall logic sees non-zero memory latency.
- Out-of-range accesses are answered with SLVERR.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, data width (STRB width = DATA_WIDTH/8).
- MEM_DEPTH, 4096, number of DATA_WIDTH words.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- RD_LATENCY, 2, wait cycles between AR handshake and RVALID (0..15).
- WR_LATENCY, 2, wait cycles between write-accept and BVALID (0..15).

Ports:
- aclk  in  1  clock.
- areset_n  in  1  asynchronous active-low reset.
- s_araddr  in  ADDR_WIDTH  read address.
- s_arvalid  in  1  read address valid.
- s_arready  out  1  read address ready.
- s_rdata  out  DATA_WIDTH  read data.
- s_rresp  out  2  read response: 00 OKAY, 10 SLVERR.
- s_rvalid  out  1  read data valid.
- s_rready  in  1  read data ready.
- s_awaddr  in  ADDR_WIDTH  write address.
- s_awvalid  in  1  write address valid.
- s_awready  out  1  write address ready.
- s_wdata  in  DATA_WIDTH  write data.
- s_wstrb  in  DATA_WIDTH/8  byte strobes.
- s_wvalid  in  1  write data valid.
- s_wready  out  1  write data ready.
- s_bresp  out  2  write response.
- s_bvalid  out  1  write response valid.
- s_bready  in  1  write response ready.

Behaviour:
- Reset: all ready/valid outputs 0; rdata, rresp and bresp 0; both FSMs IDLE. The ready outputs are registered and rise the first cycle after areset_n deasserts. An assertion mid-transaction aborts it, and no partial write is committed.
- Address decode: hit when BASE_ADDR <= addr < BASE_ADDR + 4*MEM_DEPTH; word index = (addr - BASE_ADDR) >> 2; addr[1:0] is ignored.
- Read FSM R_IDLE -> R_WAIT -> R_RESP:
  - R_IDLE: arready=1. On arvalid&arready, latch the address and load the counter with RD_LATENCY.
  - R_WAIT: counter decrements each cycle. On reaching 0, sample the memory (or 0 on a miss) into rdata, set rresp, and assert rvalid the next cycle.
  - With RD_LATENCY=0, rvalid rises the cycle after the AR handshake.
  - R_RESP: rvalid, rdata and rresp are held stable until rready. The state returns to R_IDLE on the rvalid&rready cycle, and arready re-asserts the cycle after.
- Write FSM W_IDLE -> W_WAIT -> W_RESP:
  - W_IDLE: awready=1 and wready=1, with each channel accepted independently. Once a channel's handshake completes, its ready drops and the address or data/strb is latched. The other channel may complete in the same or any later cycle.
  - When both have been accepted, load the counter with WR_LATENCY and go to W_WAIT.
  - W_WAIT: on the counter reaching 0, commit the bytes with strb=1 if the address hits, then enter W_RESP with bvalid=1 and bresp=OKAY (SLVERR on a miss, nothing written).
  - W_RESP: hold bvalid until bready, then return to W_IDLE.
- Total write latency: bvalid rises 1+WR_LATENCY cycles after the later of the AW and W handshakes.
- Read and write FSMs run concurrently.
- Same-cycle read sample and write commit to the same word: the read returns pre-write data (read-before-write).
- One outstanding transaction per direction. No IDs, bursts or reordering.
- Never drops valid without a handshake. Never changes rdata or bresp while valid is high and ready is low.

Decomposition:
- Shared define file (the existing AXI define include):
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - AXI_ADDR_WIDTH, AXI_DATA_WIDTH and AXI_STRB_WIDTH.
  - Read and write FSM state encodings.
- Sub-module axi_lite_sram_mem holds the storage array: one asynchronous read port and one synchronous byte-strobed write port, with MEM_DEPTH and DATA_WIDTH as parameters. Everything else lives in the top of this block.

Test Plan:
- RD_LATENCY=2, preload word 0=32'hDEAD_BEEF; AR 0x8000_0000 at cycle T, rready=1 -> rvalid at T+3, rdata=32'hDEADBEEF, rresp=00, arready back at T+4.
- AW 0x8000_0004 at T, W 32'h1122_3344 with strb=4'b0101 at T+3 (prior content 0), WR_LATENCY=2 -> bvalid at T+6, bresp=00; a following read returns 32'h0022_0044.
- AR 0x7FFF_FFFC and AW 0x8000_4000 (miss) -> rresp=10 with rdata=0; bresp=10 and memory is unchanged.
- rready held low 5 cycles after rvalid -> rvalid, rdata and rresp stay constant; no new AR accepted until the R handshake.
- Read and write to the same word whose sample and commit land in the same cycle, old value 32'hA5A5_A5A5, new value 32'h5A5A_5A5A -> read returns A5A5A5A5; the next read returns 5A5A5A5A.
- areset_n pulsed low during W_WAIT -> all valids 0 immediately, target word unchanged, readies high one cycle after release.
